lzma2_crc_append: RTL and testbench

Transmit-side CRC framer for the LZMA2 pipeline. Forwards a 32-byte-wide payload stream unchanged, computes CRC-32 over the payload, and appends a 4-byte CRC trailer after the last payload byte. The trailer spills into an extra beat when the last payload beat has no room for it. The block sits between the compressed-frame assembler and the output DMA and produces the trailer that the downstream verifier checks.

---
 rtl/lzma2_pkg.sv | 25 ++
 rtl/lzma2_crc_step.sv | 30 +++
 rtl/lzma2_crc_append.sv | 213 +++++++++++++++++++++
 tb/tb_lzma2_crc_append.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzma2_pkg.sv
// rtl/lzma2_pkg.sv - shared constants, error codes and state type for the LZMA2 CRC framer
package lzma2_pkg;

    localparam int          BEAT_BYTES = 32;
    localparam int          INPUT_SIZE = 32768;
    localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

    localparam logic [3:0]  ERR_NONE     = 4'd0;
    localparam logic [3:0]  ERR_OVERFLOW = 4'd1;
    localparam logic [3:0]  ERR_ABORT    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        SPILL = 2'd2
    } crc_append_state_t;

    // Byte-count code on the stream: 0 stands for a full 32-byte beat.
    function automatic logic [5:0] beat_bytes(input logic [4:0] code);
        return (code == 5'd0) ? 6'd32 : {1'b0, code};
    endfunction

endpackage

// File: rtl/lzma2_crc_step.sv
// rtl/lzma2_crc_step.sv - combinational CRC-32/BZIP2 update over the first n bytes of a beat
module lzma2_crc_step
    import lzma2_pkg::*;
(
    input  logic [31:0]             crc_in,
    input  logic [BEAT_BYTES*8-1:0] data,
    input  logic [5:0]              nbytes,
    output logic [31:0]             crc_out
);

    logic [31:0] c;

    // MSB-first bit-serial shift, unrolled over every byte; bytes at or past nbytes are skipped.
    always_comb begin
        c = crc_in;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            if (6'(i) < nbytes) begin
                for (int b = 7; b >= 0; b--) begin
                    if (c[31] ^ data[i*8+b]) begin
                        c = (c << 1) ^ CRC_POLY;
                    end else begin
                        c = c << 1;
                    end
                end
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/lzma2_crc_append.sv
// rtl/lzma2_crc_append.sv - payload pass-through with CRC-32 trailer append; LZMA2_CRC_TRAILER_LE_EN selects little-endian trailer
module lzma2_crc_append
    import lzma2_pkg::*;
#(
    parameter int DATA_BYTES      = 32,
    parameter int MAX_FRAME_BYTES = INPUT_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [DATA_BYTES*8-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    input  logic [4:0]              s_last_bytes,
    output logic [DATA_BYTES*8-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [4:0]              m_last_bytes,
    output logic [31:0]             frame_crc,
    output logic                    frame_crc_valid,
    output logic [15:0]             frame_bytes,
    output logic                    error,
    output logic [3:0]              error_code
);

    localparam int DW = DATA_BYTES * 8;

    crc_append_state_t state_q, state_d;
    logic [31:0]   crc_q, crc_d;
    logic [15:0]   frame_bytes_q, frame_bytes_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic [4:0]    m_last_bytes_q, m_last_bytes_d;
    logic [DW-1:0] spill_q, spill_d;
    logic [4:0]    spill_bytes_q, spill_bytes_d;
    logic [31:0]   frame_crc_q, frame_crc_d;
    logic          error_q, error_d;
    logic [3:0]    error_code_q, error_code_d;

    logic [5:0]    beat_n;
    logic [8:0]    shamt;
    logic [5:0]    last_lb_wide;
    logic [5:0]    spill_n;
    logic [16:0]   bytes_sum;
    logic          need_spill;
    logic          accept;
    logic          m_fire;
    logic [31:0]   crc_next;
    logic [31:0]   crc_final;
    logic [31:0]   trailer;
    logic [DW-1:0] payload_masked;
    logic [2*DW-1:0] framed;

    assign s_ready = (!m_valid_q || m_ready) && (state_q != SPILL) && !clear;
    assign accept  = s_valid && s_ready;
    assign m_fire  = m_valid_q && m_ready;

    assign beat_n       = s_last ? beat_bytes(s_last_bytes) : 6'd32;
    assign shamt        = {beat_n, 3'b000};
    assign need_spill   = (beat_n > 6'd28);
    assign last_lb_wide = beat_n + 6'd4;
    assign spill_n      = beat_n - 6'd28;
    assign bytes_sum    = {1'b0, frame_bytes_q} + {11'd0, beat_n};

    lzma2_crc_step u_crc_step (
        .crc_in  (crc_q),
        .data    (s_data),
        .nbytes  (beat_n),
        .crc_out (crc_next)
    );

    assign crc_final = crc_next ^ CRC_XOROUT;

    // Trailer packed so that bits [7:0] are the first trailer byte on the wire.
`ifdef LZMA2_CRC_TRAILER_LE_EN
    assign trailer = crc_final;
`else
    assign trailer = {crc_final[7:0], crc_final[15:8], crc_final[23:16], crc_final[31:24]};
`endif

    // Zero payload bytes past the valid count, then lay the trailer right behind them across two beats.
    always_comb begin
        payload_masked = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (6'(i) < beat_n) begin
                payload_masked[i*8 +: 8] = s_data[i*8 +: 8];
            end
        end
        framed = {{DW{1'b0}}, payload_masked} | ({{(2*DW-32){1'b0}}, trailer} << shamt);
    end

    // Next-state: output register drain/refill, frame state, CRC accumulation, byte count and errors.
    always_comb begin
        state_d        = state_q;
        crc_d          = crc_q;
        frame_bytes_d  = frame_bytes_q;
        m_data_d       = m_data_q;
        m_valid_d      = m_valid_q;
        m_last_d       = m_last_q;
        m_last_bytes_d = m_last_bytes_q;
        spill_d        = spill_q;
        spill_bytes_d  = spill_bytes_q;
        frame_crc_d    = frame_crc_q;
        error_d        = error_q;
        error_code_d   = error_code_q;

        if (m_fire) begin
            m_valid_d = 1'b0;
        end

        // In SPILL the register first holds the trailer-carrying payload beat, then the spill beat.
        if (state_q == SPILL && m_fire) begin
            if (m_last_q) begin
                state_d = IDLE;
            end else begin
                m_data_d       = spill_q;
                m_valid_d      = 1'b1;
                m_last_d       = 1'b1;
                m_last_bytes_d = spill_bytes_q;
            end
        end

        if (accept) begin
            m_valid_d     = 1'b1;
            frame_bytes_d = s_last ? 16'd0 : bytes_sum[15:0];
            if (bytes_sum > 17'(MAX_FRAME_BYTES)) begin
                error_d      = 1'b1;
                error_code_d = ERR_OVERFLOW;
            end
            if (!s_last) begin
                m_data_d       = s_data;
                m_last_d       = 1'b0;
                m_last_bytes_d = 5'd0;
                crc_d          = crc_next;
                state_d        = PASS;
            end else begin
                crc_d       = CRC_INIT;
                frame_crc_d = crc_final;
                m_data_d    = framed[DW-1:0];
                spill_d     = framed[2*DW-1:DW];
                if (need_spill) begin
                    m_last_d       = 1'b0;
                    m_last_bytes_d = 5'd0;
                    spill_bytes_d  = spill_n[4:0];
                    state_d        = SPILL;
                end else begin
                    m_last_d       = 1'b1;
                    m_last_bytes_d = last_lb_wide[4:0];
                    state_d        = IDLE;
                end
            end
        end

        if (clear) begin
            if (state_q != IDLE) begin
                error_d      = 1'b1;
                error_code_d = ERR_ABORT;
            end else begin
                error_d      = 1'b0;
                error_code_d = ERR_NONE;
            end
            crc_d         = CRC_INIT;
            frame_bytes_d = 16'd0;
            state_d       = IDLE;
            m_valid_d     = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            crc_q          <= CRC_INIT;
            frame_bytes_q  <= 16'd0;
            m_data_q       <= '0;
            m_valid_q      <= 1'b0;
            m_last_q       <= 1'b0;
            m_last_bytes_q <= 5'd0;
            spill_q        <= '0;
            spill_bytes_q  <= 5'd0;
            frame_crc_q    <= 32'd0;
            error_q        <= 1'b0;
            error_code_q   <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            crc_q          <= crc_d;
            frame_bytes_q  <= frame_bytes_d;
            m_data_q       <= m_data_d;
            m_valid_q      <= m_valid_d;
            m_last_q       <= m_last_d;
            m_last_bytes_q <= m_last_bytes_d;
            spill_q        <= spill_d;
            spill_bytes_q  <= spill_bytes_d;
            frame_crc_q    <= frame_crc_d;
            error_q        <= error_d;
            error_code_q   <= error_code_d;
        end
    end

    assign m_data          = m_data_q;
    assign m_valid         = m_valid_q;
    assign m_last          = m_last_q;
    assign m_last_bytes    = m_last_bytes_q;
    assign frame_crc       = frame_crc_q;
    assign frame_crc_valid = m_fire && m_last_q;
    assign frame_bytes     = frame_bytes_q;
    assign error           = error_q;
    assign error_code      = error_code_q;

endmodule

// File: tb/tb_lzma2_crc_append.sv
// tb/tb_lzma2_crc_append.sv - scoreboard bench for lzma2_crc_append
module tb_lzma2_crc_append;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic [255:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic         s_last;
    logic [4:0]   s_last_bytes;
    logic [255:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic [4:0]   m_last_bytes;
    logic [31:0]  frame_crc;
    logic         frame_crc_valid;
    logic [15:0]  frame_bytes;
    logic         error;
    logic [3:0]   error_code;

    typedef struct {
        logic [255:0] data;
        logic         last;
        logic [4:0]   lb;
        logic [31:0]  crc;
    } beat_t;

    beat_t        exp_q[$];
    int           tests_run    = 0;
    int           tests_failed = 0;
    int           beats_seen   = 0;
    logic [255:0] seen_data;
    logic [4:0]   seen_lb;

    always #5 clk = ~clk;

    lzma2_crc_append dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_last          (s_last),
        .s_last_bytes    (s_last_bytes),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last          (m_last),
        .m_last_bytes    (m_last_bytes),
        .frame_crc       (frame_crc),
        .frame_crc_valid (frame_crc_valid),
        .frame_bytes     (frame_bytes),
        .error           (error),
        .error_code      (error_code)
    );

    function automatic logic [31:0] ref_crc(input logic [7:0] bytes[$]);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        foreach (bytes[k]) begin
            r = r ^ {bytes[k], 24'h0};
            repeat (8) r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
        end
        return ~r;
    endfunction

    function automatic logic [255:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Output stream = payload bytes followed by the 4 trailer bytes, chopped into 32-byte beats.
    task automatic push_expected(input logic [7:0] pl[$]);
        logic [7:0]  st[$];
        logic [31:0] c;
        int          nb;
        beat_t       e;
        c  = ref_crc(pl);
        st = pl;
`ifdef LZMA2_CRC_TRAILER_LE_EN
        st.push_back(c[7:0]);   st.push_back(c[15:8]);
        st.push_back(c[23:16]); st.push_back(c[31:24]);
`else
        st.push_back(c[31:24]); st.push_back(c[23:16]);
        st.push_back(c[15:8]);  st.push_back(c[7:0]);
`endif
        nb = (st.size() + 31) / 32;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            for (int k = 0; k < 32; k++) begin
                if (b * 32 + k < st.size()) e.data[k*8 +: 8] = st[b*32+k];
            end
            e.last = (b == nb - 1);
            e.lb   = e.last ? 5'(st.size() % 32) : 5'd0;
            e.crc  = c;
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every output handshake is compared against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            beat_t e;
            beats_seen++;
            seen_data = m_data;
            seen_lb   = m_last_bytes;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_beat got data=%h last=%0d lb=%0d, expected no beat", m_data, m_last, m_last_bytes);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e.data || m_last !== e.last || m_last_bytes !== e.lb) begin
                    tests_failed++;
                    $display("FAIL beat got data=%h last=%0d lb=%0d, expected data=%h last=%0d lb=%0d",
                             m_data, m_last, m_last_bytes, e.data, e.last, e.lb);
                end
                tests_run++;
                if (e.last) begin
                    if (frame_crc_valid !== 1'b1 || frame_crc !== e.crc) begin
                        tests_failed++;
                        $display("FAIL frame_crc got valid=%0d crc=%h, expected valid=1 crc=%h", frame_crc_valid, frame_crc, e.crc);
                    end
                end else if (frame_crc_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL frame_crc_valid got 1 on a non-last beat, expected 0");
                end
            end
        end
    end

    task automatic drive_beat(input logic [255:0] d, input logic last, input logic [4:0] lb);
        int waited;
        waited       = 0;
        s_data       = d;
        s_last       = last;
        s_last_bytes = lb;
        s_valid      = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            waited++;
            if (waited > 500) begin
                tests_run++;
                tests_failed++;
                $display("FAIL accept_timeout got s_ready=0 for %0d cycles, expected acceptance", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] pl[$], input bit ovf_check);
        int           nb;
        int           n;
        logic [255:0] d;
        logic         last;
        push_expected(pl);
        nb = (pl.size() + 31) / 32;
        for (int b = 0; b < nb; b++) begin
            d = rand_beat();
            for (int k = 0; k < 32; k++) begin
                if (b * 32 + k < pl.size()) d[k*8 +: 8] = pl[b*32+k];
            end
            last = (b == nb - 1);
            n    = pl.size() - b * 32;
            drive_beat(d, last, last ? 5'(n) : 5'($urandom_range(0, 31)));
            if (ovf_check && b == 1023) begin
                tests_run++;
                if (error !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ovf_early got error=%0d after 32768 bytes, expected 0", error);
                end
            end
            if (ovf_check && b == 1024) begin
                tests_run++;
                if (error !== 1'b1 || error_code !== 4'd1) begin
                    tests_failed++;
                    $display("FAIL ovf_set got error=%0d code=%0d, expected error=1 code=1", error, error_code);
                end
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0 || m_valid) begin
            tests_failed++;
            $display("FAIL drain got %0d beats pending m_valid=%0d, expected 0 pending", exp_q.size(), m_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic golden_frame();
        logic [7:0] pl[$];
        for (int k = 0; k < 9; k++) pl.push_back(8'(8'h31 + k));
        send_frame(pl, 1'b0);
        wait_drain();
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || frame_crc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got s_ready=%0d m_valid=%0d m_last=%0d crc_valid=%0d, expected 1 0 0 0",
                     s_ready, m_valid, m_last, frame_crc_valid);
        end
        tests_run++;
        if (m_data !== 256'd0 || m_last_bytes !== 5'd0 || frame_bytes !== 16'd0 || frame_crc !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_data got m_data=%h lb=%0d bytes=%0d crc=%h, expected all 0", m_data, m_last_bytes, frame_bytes, frame_crc);
        end
        tests_run++;
        if (error !== 1'b0 || error_code !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_err got error=%0d code=%0d, expected 0 0", error, error_code);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_golden();
        logic [31:0] exp_tr;
`ifdef LZMA2_CRC_TRAILER_LE_EN
        exp_tr = 32'hFC89_1918;
`else
        exp_tr = 32'h1819_89FC;
`endif
        golden_frame();
        tests_run++;
        if (seen_data[72 +: 32] !== exp_tr || seen_lb !== 5'd13) begin
            tests_failed++;
            $display("FAIL golden_trailer got bytes9..12=%h lb=%0d, expected %h lb=13", seen_data[72 +: 32], seen_lb, exp_tr);
        end
        tests_run++;
        if (frame_crc !== 32'hFC89_1918 || frame_bytes !== 16'd0) begin
            tests_failed++;
            $display("FAIL golden_crc got crc=%h bytes=%0d, expected crc=fc891918 bytes=0", frame_crc, frame_bytes);
        end
    endtask

    task automatic test_spill();
        int         ns[5]  = '{28, 29, 30, 31, 32};
        int         pre[5] = '{0, 1, 0, 2, 0};
        logic [7:0] pl[$];
        int         start;
        int         exp_beats;
        logic [4:0] exp_lb;
        foreach (ns[i]) begin
            pl.delete();
            for (int k = 0; k < pre[i] * 32 + ns[i]; k++) pl.push_back(8'($urandom));
            start = beats_seen;
            send_frame(pl, 1'b0);
            wait_drain();
            exp_beats = pre[i] + ((ns[i] > 28) ? 2 : 1);
            exp_lb    = (ns[i] > 28) ? 5'(ns[i] - 28) : 5'((ns[i] + 4) % 32);
            tests_run++;
            if (beats_seen - start !== exp_beats || seen_lb !== exp_lb) begin
                tests_failed++;
                $display("FAIL spill_n%0d got beats=%0d lb=%0d, expected beats=%0d lb=%0d",
                         ns[i], beats_seen - start, seen_lb, exp_beats, exp_lb);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]   pl[$];
        logic [255:0] held;
        for (int k = 0; k < 5 * 32 + 17; k++) pl.push_back(8'($urandom));
        fork
            send_frame(pl, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                m_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (i == 0) held = m_data;
                    tests_run++;
                    if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== held) begin
                        tests_failed++;
                        $display("FAIL stall_cycle%0d got m_valid=%0d s_ready=%0d data=%h, expected 1 0 data=%h",
                                 i, m_valid, s_ready, m_data, held);
                    end
                end
                @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] pl[$];
        bit         done;
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 8; f++) begin
                    pl.delete();
                    for (int k = 0; k < $urandom_range(1, 130); k++) pl.push_back(8'($urandom));
                    send_frame(pl, 1'b0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
                m_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_overflow();
        logic [7:0] pl[$];
        for (int k = 0; k < 1025 * 32; k++) pl.push_back(8'($urandom));
        send_frame(pl, 1'b1);
        wait_drain();
        tests_run++;
        if (error !== 1'b1 || error_code !== 4'd1) begin
            tests_failed++;
            $display("FAIL ovf_sticky got error=%0d code=%0d, expected 1 1", error, error_code);
        end
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        tests_run++;
        if (error !== 1'b0 || error_code !== 4'd0) begin
            tests_failed++;
            $display("FAIL idle_clear got error=%0d code=%0d, expected 0 0", error, error_code);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clear();
        logic [255:0] d;
        beat_t        e;
        for (int b = 0; b < 3; b++) begin
            d      = rand_beat();
            e.data = d;
            e.last = 1'b0;
            e.lb   = 5'd0;
            e.crc  = 32'd0;
            exp_q.push_back(e);
            drive_beat(d, 1'b0, 5'($urandom_range(0, 31)));
        end
        tests_run++;
        if (frame_bytes !== 16'd96) begin
            tests_failed++;
            $display("FAIL clear_precount got frame_bytes=%0d, expected 96", frame_bytes);
        end
        clear        = 1'b1;
        s_data       = rand_beat();
        s_last       = 1'b1;
        s_last_bytes = 5'd5;
        s_valid      = 1'b1;
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_ready got s_ready=%0d, expected 0", s_ready);
        end
        @(posedge clk);
        #1;
        clear   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        tests_run++;
        if (m_valid !== 1'b0 || frame_bytes !== 16'd0 || error !== 1'b1 || error_code !== 4'd3) begin
            tests_failed++;
            $display("FAIL clear_abort got m_valid=%0d bytes=%0d error=%0d code=%0d, expected 0 0 1 3",
                     m_valid, frame_bytes, error, error_code);
        end
        @(posedge clk);
        #1;
        wait_drain();
        golden_frame();
        tests_run++;
        if (frame_crc !== 32'hFC89_1918 || error_code !== 4'd3) begin
            tests_failed++;
            $display("FAIL post_clear_crc got crc=%h code=%0d, expected crc=fc891918 code=3", frame_crc, error_code);
        end
    endtask

    initial begin
        rst          = 1'b1;
        clear        = 1'b0;
        s_valid      = 1'b0;
        s_last       = 1'b0;
        s_last_bytes = 5'd0;
        s_data       = '0;
        m_ready      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_golden();
        test_spill();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
